// File: rtl/response_block_bridge_ot_pkg.sv
// Shared constants and helpers for the per-master XBAR bridge port.
package bridge_pkg;
   localparam int ERR_UNEXP_RSP = 0;
   localparam int ERR_MULTI_RSP = 1;
   localparam int MAX_PORTS     = 64;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic int onehot_lsb_idx(input logic [MAX_PORTS-1:0] vec);
      onehot_lsb_idx = 0;
      for (int i = MAX_PORTS-1; i >= 0; i--)
         if (vec[i]) onehot_lsb_idx = i;
   endfunction
endpackage

// File: rtl/response_block_bridge_ot_if.sv
// Master-facing and slave-facing signals of one bridge port.
interface response_block_bridge_ot_if #(
   parameter int N_SLAVE         = 16,
   parameter int ID_WIDTH        = 17,
   parameter int DATA_WIDTH      = 32,
   parameter int AUX_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 4
);
   localparam int CW = $clog2(MAX_OUTSTANDING+1);

   logic                                 data_req_i;
   logic [N_SLAVE-1:0]                   destination_i;
   logic                                 data_gnt_o;
   logic [N_SLAVE-1:0]                   data_req_o;
   logic [N_SLAVE-1:0]                   data_gnt_i;
   logic [ID_WIDTH-1:0]                  data_ID_o;
   logic [N_SLAVE-1:0]                   data_r_valid_i;
   logic [N_SLAVE-1:0][DATA_WIDTH-1:0]   data_r_rdata_i;
   logic [N_SLAVE-1:0]                   data_r_opc_i;
   logic [N_SLAVE-1:0][AUX_WIDTH-1:0]    data_r_aux_i;
   logic                                 data_r_valid_o;
   logic [DATA_WIDTH-1:0]                data_r_rdata_o;
   logic                                 data_r_opc_o;
   logic [AUX_WIDTH-1:0]                 data_r_aux_o;
   logic [CW-1:0]                        outstanding_o;
   logic [1:0]                           err_o;

   modport slave (
      input  data_req_i, destination_i, data_gnt_i, data_r_valid_i,
             data_r_rdata_i, data_r_opc_i, data_r_aux_i,
      output data_gnt_o, data_req_o, data_ID_o, data_r_valid_o,
             data_r_rdata_o, data_r_opc_o, data_r_aux_o, outstanding_o, err_o
   );

   modport master (
      output data_req_i, destination_i, data_gnt_i, data_r_valid_i,
             data_r_rdata_i, data_r_opc_i, data_r_aux_i,
      input  data_gnt_o, data_req_o, data_ID_o, data_r_valid_o,
             data_r_rdata_o, data_r_opc_o, data_r_aux_o, outstanding_o, err_o
   );
endinterface

// File: rtl/response_block_bridge_ot_rsp_mux_bridge.sv
// N-to-1 priority response mux: lowest-index valid wins.
module rsp_mux_bridge
   import bridge_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 41
) (
   input  logic [N-1:0]        valid,
   input  logic [N-1:0][W-1:0] payload,
   output logic                valid_out,
   output logic [W-1:0]        payload_out,
   output logic [N-1:0]        sel_oh,
   output logic                multi_hit
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] idx;

   assign idx       = IW'(onehot_lsb_idx(MAX_PORTS'(valid)));
   assign valid_out = |valid;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_hit = |(valid & (valid - N'(1)));

   always_comb begin
      sel_oh      = '0;
      payload_out = '0;
      if (valid_out) begin
         sel_oh[idx] = 1'b1;
         payload_out = payload[idx];
      end
   end
endmodule

// File: rtl/response_block_bridge_ot.sv
// Per-master bridge port: gates requests to one slave at a time, caps outstanding, returns responses.
module response_block_bridge_ot
   import bridge_pkg::*;
#(
   parameter int ID              = 1,
   parameter int ID_WIDTH        = 17,
   parameter int N_SLAVE         = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int AUX_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RESP_REG        = 1
) (
   input logic                      clk,
   input logic                      rst,
   response_block_bridge_ot_if.slave bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING+1);
   localparam int PW = DATA_WIDTH + AUX_WIDTH + 1;

   logic [CW-1:0]              cnt;
   logic [N_SLAVE-1:0]         last_dest;
   logic [1:0]                 err;
   logic                       allow, gnt, dec;
   logic [N_SLAVE-1:0]         req;
   logic [N_SLAVE-1:0][PW-1:0] rsp_pl;
   logic                       m_valid, m_multi;
   logic [PW-1:0]              m_pl;
   logic [N_SLAVE-1:0]         m_sel;

   // Responses stay ordered because new requests may only follow the current target.
   assign allow = (cnt < CW'(MAX_OUTSTANDING)) && ((cnt == '0) || (bus.destination_i == last_dest));
   assign req   = {N_SLAVE{bus.data_req_i & allow}} & bus.destination_i;
   assign gnt   = |(req & bus.data_gnt_i);

   assign bus.data_req_o    = req;
   assign bus.data_gnt_o    = gnt;
   assign bus.data_ID_o     = ID_WIDTH'(1) << ID;
   assign bus.outstanding_o = cnt;
   assign bus.err_o         = err;

   for (genvar s = 0; s < N_SLAVE; s++) begin : g_pack
      assign rsp_pl[s] = {bus.data_r_opc_i[s], bus.data_r_aux_i[s], bus.data_r_rdata_i[s]};
   end

   rsp_mux_bridge #(.N(N_SLAVE), .W(PW)) u_mux (
      .valid       (bus.data_r_valid_i),
      .payload     (rsp_pl),
      .valid_out   (m_valid),
      .payload_out (m_pl),
      .sel_oh      (m_sel),
      .multi_hit   (m_multi)
   );

   // A stray response at cnt==0 must not wrap the counter.
   assign dec = m_valid && (cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         last_dest <= '0;
         err       <= '0;
      end else begin
         if (gnt && !dec)      cnt <= cnt + CW'(1);
         else if (!gnt && dec) cnt <= cnt - CW'(1);
         if (gnt) last_dest <= bus.destination_i;
         if (m_valid && ((cnt == '0) || !(|(m_sel & last_dest))))
            err[ERR_UNEXP_RSP] <= 1'b1;
         if (m_multi) err[ERR_MULTI_RSP] <= 1'b1;
      end
   end

   if (RESP_REG != 0) begin : g_rsp_reg
      logic          r_valid;
      logic [PW-1:0] r_pl;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_pl    <= '0;
         end else begin
            r_valid <= m_valid;
            if (m_valid) r_pl <= m_pl;
         end
      end
      assign bus.data_r_valid_o = r_valid;
      assign {bus.data_r_opc_o, bus.data_r_aux_o, bus.data_r_rdata_o} = r_pl;
   end else begin : g_rsp_comb
      assign bus.data_r_valid_o = m_valid;
      assign {bus.data_r_opc_o, bus.data_r_aux_o, bus.data_r_rdata_o} = m_pl;
   end
endmodule
